// File: rtl/ddr3_read_training_tap_sweep.sv
// ddr3_read_training_tap_sweep
//   Per-lane DQ read-training sequencer. It sweeps every IOD delay tap,
//   qualifies each tap with the eye-monitor EARLY/LATE flags, keeps the widest
//   contiguous passing window, then walks the delay line back to its centre.
//
// Ports
//   FAB_CLK, ARST                 fabric clock, async active-high reset
//   START                         one-cycle training request (ignored while BUSY)
//   BUSY, DONE, FAIL              status (DONE pulse, FAIL sticky until next START)
//   TAP_OUT                       delay-line tap as tracked by this block
//   EYE_START, EYE_WIDTH          best window, valid from DONE
//   DELAY_LINE_LOAD/MOVE/DIRECTION, EYE_MONITOR_CLEAR_FLAGS   controls to IOD
//   EYE_MONITOR_EARLY/LATE, DELAY_LINE_OUT_OF_RANGE          status from IOD
//
// Optional build macro
//   RT_PASS_COUNT_EN  adds PASS_COUNT: total passing taps seen in the sweep.
module ddr3_read_training_tap_sweep #(
  parameter int unsigned NUM_TAPS      = 128,
  parameter int unsigned TAP_W         = 7,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SAMPLE_CYCLES = 16,
  parameter int unsigned MIN_EYE       = 8
) (
  input  logic             FAB_CLK,
  input  logic             ARST,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [TAP_W-1:0] TAP_OUT,
  output logic [TAP_W-1:0] EYE_START,
  output logic [TAP_W:0]   EYE_WIDTH,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic             DELAY_LINE_OUT_OF_RANGE
`ifdef RT_PASS_COUNT_EN
  ,
  output logic [TAP_W:0]   PASS_COUNT
`endif
);

  localparam int unsigned LEN_W   = TAP_W + 1;
  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [3:0] {
    IDLE, LOAD, CLEAR, SETTLE, SAMPLE, EVAL, STEP, CALC, CENTER, DONE_S, FAIL_S
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               phase, phase_n;   // CENTER: 0 = pulse cycle, 1 = gap cycle
  logic               bad, bad_n;
  logic [TAP_W-1:0]   tap_n;
  logic [TAP_W-1:0]   cur_start, cur_start_n, best_start, best_start_n;
  logic [LEN_W-1:0]   cur_len, cur_len_n, best_len, best_len_n;
  logic [TAP_W-1:0]   centre, centre_n;
  logic               fail_n, dir_n;
  logic [TAP_W-1:0]   eye_start_n;
  logic [LEN_W-1:0]   eye_width_n;
  logic [LEN_W-1:0]   eval_len, centre_sum;
  logic [TAP_W-1:0]   eval_start;
`ifdef RT_PASS_COUNT_EN
  logic [LEN_W-1:0]   pass_n;
`endif

  // Next-state, datapath updates and output decode
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    phase_n      = phase;
    bad_n        = bad;
    tap_n        = TAP_OUT;
    cur_start_n  = cur_start;
    cur_len_n    = cur_len;
    best_start_n = best_start;
    best_len_n   = best_len;
    centre_n     = centre;
    fail_n       = FAIL;
    dir_n        = DELAY_LINE_DIRECTION;
    eye_start_n  = EYE_START;
    eye_width_n  = EYE_WIDTH;
`ifdef RT_PASS_COUNT_EN
    pass_n       = PASS_COUNT;
`endif
    // Window bookkeeping for the tap just sampled; a failing tap closes the run
    eval_len   = bad ? '0 : cur_len + LEN_W'(1);
    eval_start = (!bad && cur_len == '0) ? TAP_OUT : cur_start;
    centre_sum = LEN_W'(best_start) + (best_len >> 1);

    case (state)
      IDLE: if (START) state_n = LOAD;
      LOAD: begin
        tap_n        = '0;
        cur_start_n  = '0;
        cur_len_n    = '0;
        best_start_n = '0;
        best_len_n   = '0;
`ifdef RT_PASS_COUNT_EN
        pass_n       = '0;
`endif
        state_n      = CLEAR;
      end
      CLEAR: begin
        bad_n   = 1'b0;
        cnt_n   = '0;
        state_n = SETTLE;
      end
      SETTLE: begin
        if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = SAMPLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      SAMPLE: begin
        bad_n = bad | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
        if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = EVAL;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      EVAL: begin
        cur_len_n   = eval_len;
        cur_start_n = eval_start;
        // Strictly greater: on a tie the earlier window wins
        if (eval_len > best_len) begin
          best_len_n   = eval_len;
          best_start_n = eval_start;
        end
`ifdef RT_PASS_COUNT_EN
        if (!bad) pass_n = PASS_COUNT + LEN_W'(1);
`endif
        state_n = (TAP_OUT == TAP_W'(NUM_TAPS - 1)) ? CALC : STEP;
      end
      STEP: begin
        if (DELAY_LINE_OUT_OF_RANGE) begin
          state_n = FAIL_S;
        end else begin
          tap_n   = TAP_OUT + TAP_W'(1);
          state_n = CLEAR;
        end
      end
      CALC: begin
        centre_n = TAP_W'(centre_sum);
        phase_n  = 1'b0;
        if (best_len < LEN_W'(MIN_EYE))         state_n = FAIL_S;
        else if (TAP_W'(centre_sum) == TAP_OUT) state_n = DONE_S;
        else                                     state_n = CENTER;
      end
      CENTER: begin
        if (DELAY_LINE_OUT_OF_RANGE) begin
          state_n = FAIL_S;
        end else if (!phase) begin
          tap_n   = TAP_OUT - TAP_W'(1);
          phase_n = 1'b1;
        end else if (TAP_OUT == centre) begin
          state_n = DONE_S;
        end else begin
          phase_n = 1'b0;
        end
      end
      DONE_S:  state_n = IDLE;
      FAIL_S:  state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Direction changes only in non-MOVE cycles ahead of each move phase
    if (state_n == LOAD) begin
      fail_n = 1'b0;
      dir_n  = 1'b1;
    end
    if (state_n == CALC)   dir_n  = 1'b0;
    if (state_n == FAIL_S) fail_n = 1'b1;
    if (state_n == DONE_S) begin
      eye_start_n = best_start_n;
      eye_width_n = best_len_n;
    end
  end

  // State and registered outputs, decoded from the next state so each
  // control pulse lines up with the state it belongs to
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state                   <= IDLE;
      cnt                     <= '0;
      phase                   <= 1'b0;
      bad                     <= 1'b0;
      cur_start               <= '0;
      cur_len                 <= '0;
      best_start              <= '0;
      best_len                <= '0;
      centre                  <= '0;
      TAP_OUT                 <= '0;
      BUSY                    <= 1'b0;
      DONE                    <= 1'b0;
      FAIL                    <= 1'b0;
      EYE_START               <= '0;
      EYE_WIDTH               <= '0;
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      DELAY_LINE_DIRECTION    <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
`ifdef RT_PASS_COUNT_EN
      PASS_COUNT              <= '0;
`endif
    end else begin
      state                   <= state_n;
      cnt                     <= cnt_n;
      phase                   <= phase_n;
      bad                     <= bad_n;
      cur_start               <= cur_start_n;
      cur_len                 <= cur_len_n;
      best_start              <= best_start_n;
      best_len                <= best_len_n;
      centre                  <= centre_n;
      TAP_OUT                 <= tap_n;
      BUSY                    <= (state_n != IDLE);
      DONE                    <= (state_n == DONE_S);
      FAIL                    <= fail_n;
      EYE_START               <= eye_start_n;
      EYE_WIDTH               <= eye_width_n;
      DELAY_LINE_LOAD         <= (state_n == LOAD);
      DELAY_LINE_MOVE         <= (state_n == STEP) || (state_n == CENTER && !phase_n);
      DELAY_LINE_DIRECTION    <= dir_n;
      EYE_MONITOR_CLEAR_FLAGS <= (state_n == CLEAR);
`ifdef RT_PASS_COUNT_EN
      PASS_COUNT              <= pass_n;
`endif
    end
  end

endmodule

// File: tb/tb_ddr3_read_training_tap_sweep.sv
// Self-checking bench for ddr3_read_training_tap_sweep. A small IOD model
// tracks the delay-line position from LOAD/MOVE/DIRECTION and raises sticky
// EARLY/LATE flags (randomly) on taps that are not in pass_mask.
// Expected results come from enumerating the maximal passing runs of the mask.
module tb_ddr3_read_training_tap_sweep;
  localparam int NUM_TAPS = 128;
  localparam int TAP_W    = 7;
  localparam int SETTLE   = 8;
  localparam int SAMPLE   = 16;
  localparam int MIN_EYE  = 8;
  localparam int MAX_CYC  = 6000;

  logic             FAB_CLK = 1'b0;
  logic             ARST = 1'b1;
  logic             START = 1'b0;
  logic             EARLY = 1'b0;
  logic             LATE = 1'b0;
  logic             OOR = 1'b0;
  logic             BUSY, DONE, FAIL;
  logic [TAP_W-1:0] TAP_OUT, EYE_START;
  logic [TAP_W:0]   EYE_WIDTH;
  logic             LOAD, MOVE, DIR, CLR;
`ifdef RT_PASS_COUNT_EN
  logic [TAP_W:0]   PASS_COUNT;
`endif

  ddr3_read_training_tap_sweep dut (
    .FAB_CLK(FAB_CLK), .ARST(ARST), .START(START),
    .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL),
    .TAP_OUT(TAP_OUT), .EYE_START(EYE_START), .EYE_WIDTH(EYE_WIDTH),
    .DELAY_LINE_LOAD(LOAD), .DELAY_LINE_MOVE(MOVE), .DELAY_LINE_DIRECTION(DIR),
    .EYE_MONITOR_CLEAR_FLAGS(CLR),
    .EYE_MONITOR_EARLY(EARLY), .EYE_MONITOR_LATE(LATE),
    .DELAY_LINE_OUT_OF_RANGE(OOR)
`ifdef RT_PASS_COUNT_EN
    , .PASS_COUNT(PASS_COUNT)
`endif
  );

  always #5 FAB_CLK = ~FAB_CLK;

  bit   pass_mask [NUM_TAPS];
  int   pos, fwd_cnt, back_cnt, fwd_since_load, oor_step;
  int   excl_viol, dir_viol;
  logic prev_dir = 1'b0;
  int   n_vec, n_mis;

  // IOD model and protocol watcher, evaluated mid-cycle
  always @(negedge FAB_CLK) begin
    if (!ARST) begin
      if ($countones({LOAD, MOVE, CLR}) > 1) excl_viol++;
      if (MOVE && DIR !== prev_dir) dir_viol++;
      if (LOAD) begin
        pos = 0;
        fwd_since_load = 0;
      end else if (MOVE) begin
        if (DIR) begin
          pos++; fwd_cnt++; fwd_since_load++;
        end else begin
          pos--; back_cnt++;
        end
      end
      OOR = (oor_step != 0) && MOVE && DIR && (fwd_since_load == oor_step);
      if (CLR) begin
        EARLY = 1'b0;
        LATE  = 1'b0;
      end else begin
        bit good;
        good = 1'b0;
        if (pos >= 0 && pos < NUM_TAPS) good = pass_mask[pos];
        if (!good) begin
          EARLY = EARLY | 1'($urandom_range(0, 1));
          LATE  = LATE  | 1'($urandom_range(0, 1));
        end
      end
    end
    prev_dir = DIR;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mask();
    for (int t = 0; t < NUM_TAPS; t++) pass_mask[t] = 1'b0;
  endtask

  task automatic set_pass(input int a, input int b);
    for (int t = a; t <= b && t < NUM_TAPS; t++) pass_mask[t] = 1'b1;
  endtask

  // Best window = longest maximal run of passing taps, earliest on ties
  function automatic void ref_eye(output int s, output int w, output int pc);
    s = 0; w = 0; pc = 0;
    for (int t = 0; t < NUM_TAPS; t++) begin
      if (pass_mask[t]) pc++;
      if (pass_mask[t] && (t == 0 || !pass_mask[t-1])) begin
        int e;
        e = t;
        while (e < NUM_TAPS && pass_mask[e]) e++;
        if (e - t > w) begin
          w = e - t; s = t;
        end
      end
    end
  endfunction

  // Pulse START and run until DONE or FAIL (k = cycles after the START cycle)
  task automatic run_sweep(input int x1, input int x2, output int lat, output bit gd,
                           output bit gf, output bit f2, output bit l1,
                           output int fw, output int bk);
    int f0, b0;
    f0 = fwd_cnt; b0 = back_cnt;
    lat = 0; gd = 0; gf = 0; f2 = 0; l1 = 0;
    START = 1'b1;
    for (int k = 1; k <= MAX_CYC; k++) begin
      @(negedge FAB_CLK);
      START = (k == x1 || k == x2);
      if (k == 1) l1 = LOAD && !MOVE && !CLR;
      if (k == 2) f2 = FAIL;
      if (DONE) begin gd = 1; lat = k; break; end
      if (k >= 2 && FAIL) begin gf = 1; lat = k; break; end
    end
    START = 1'b0;
    fw = fwd_cnt - f0;
    bk = back_cnt - b0;
  endtask

  // Compare a finished sweep against the reference
  task automatic verify(input string tag, input int lat, input bit gd, input bit gf,
                        input int fw, input int bk);
    int s, w, pc, c, exp_lat;
    ref_eye(s, w, pc);
    if (w >= MIN_EYE) begin
      c = s + w / 2;
      // Latency counts the START cycle and the DONE cycle
      exp_lat = 2 + NUM_TAPS * (1 + SETTLE + SAMPLE + 1) + (NUM_TAPS - 1) + 1
                + 2 * (NUM_TAPS - 1 - c) + 1;
      check({tag, ".done"},      64'(gd), 64'(1));
      check({tag, ".eye_start"}, 64'(EYE_START), 64'(s));
      check({tag, ".eye_width"}, 64'(EYE_WIDTH), 64'(w));
      check({tag, ".tap_out"},   64'(TAP_OUT), 64'(c));
      check({tag, ".dec_moves"}, 64'(bk), 64'(NUM_TAPS - 1 - c));
      check({tag, ".latency"},   64'(lat), 64'(exp_lat - 1));
    end else begin
      check({tag, ".fail"},      64'(gf), 64'(1));
      check({tag, ".no_done"},   64'(gd), 64'(0));
      check({tag, ".tap_out"},   64'(TAP_OUT), 64'(NUM_TAPS - 1));
      check({tag, ".dec_moves"}, 64'(bk), 64'(0));
    end
    check({tag, ".inc_moves"}, 64'(fw), 64'(NUM_TAPS - 1));
`ifdef RT_PASS_COUNT_EN
    check({tag, ".pass_count"}, 64'(PASS_COUNT), 64'(pc));
`endif
    check({tag, ".excl"}, 64'(excl_viol), 64'(0));
    check({tag, ".dir"},  64'(dir_viol), 64'(0));
    @(negedge FAB_CLK);
    check({tag, ".idle"}, 64'({BUSY, DONE}), 64'(0));
  endtask

  logic [28:0] all_outs;
  assign all_outs = {BUSY, DONE, FAIL, TAP_OUT, EYE_START, EYE_WIDTH, LOAD, MOVE, DIR, CLR};

  initial begin
    int lat, fw, bk, m0;
    bit gd, gf, f2, l1;

    // Reset
    repeat (3) @(negedge FAB_CLK);
    check("rst.outs_in_reset", 64'(all_outs), 64'(0));
    ARST = 1'b0;
    @(negedge FAB_CLK);
    check("rst.outs_after", 64'(all_outs), 64'(0));

    // Single window 40..79 -> centre 60, 67 decrement pulses
    clear_mask(); set_pass(40, 79);
    run_sweep(0, 0, lat, gd, gf, f2, l1, fw, bk);
    check("win40.eye_start", 64'(EYE_START), 64'(40));
    check("win40.tap_out", 64'(TAP_OUT), 64'(60));
    check("win40.dec_moves", 64'(bk), 64'(67));
    verify("win40", lat, gd, gf, fw, bk);

    // Tie between 10..19 and 50..59 keeps the earlier one
    clear_mask(); set_pass(10, 19); set_pass(50, 59);
    run_sweep(0, 0, lat, gd, gf, f2, l1, fw, bk);
    check("tie.eye_start", 64'(EYE_START), 64'(10));
    check("tie.tap_out", 64'(TAP_OUT), 64'(15));
    verify("tie", lat, gd, gf, fw, bk);

    // Narrow eye -> FAIL, left at last tap
    clear_mask(); set_pass(100, 104);
    run_sweep(0, 0, lat, gd, gf, f2, l1, fw, bk);
    verify("narrow", lat, gd, gf, fw, bk);
    check("narrow.fail_sticky", 64'(FAIL), 64'(1));

    // Next START clears FAIL
    clear_mask(); set_pass(40, 79);
    run_sweep(0, 0, lat, gd, gf, f2, l1, fw, bk);
    check("restart.fail_cleared", 64'(f2), 64'(0));
    verify("restart", lat, gd, gf, fw, bk);

    // Out-of-range on forward step 30 aborts
    oor_step = 30;
    run_sweep(0, 0, lat, gd, gf, f2, l1, fw, bk);
    check("oor.fail", 64'(gf), 64'(1));
    check("oor.inc_moves", 64'(fw), 64'(30));
    m0 = fwd_cnt + back_cnt;
    @(negedge FAB_CLK);
    check("oor.busy_low", 64'(BUSY), 64'(0));
    repeat (40) @(negedge FAB_CLK);
    check("oor.no_more_moves", 64'(fwd_cnt + back_cnt), 64'(m0));
    oor_step = 0;

    // ARST in the middle of sampling tap 20
    START = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b0;
    for (int k = 0; k < 2000 && pos != 20; k++) @(negedge FAB_CLK);
    check("arst.reached_tap20", 64'(pos), 64'(20));
    repeat (12) @(negedge FAB_CLK);
    check("arst.busy_before", 64'(BUSY), 64'(1));
    ARST = 1'b1;
    #1;
    check("arst.outs_zero", 64'(all_outs), 64'(0));
    @(negedge FAB_CLK);
    ARST = 1'b0;
    @(negedge FAB_CLK);
    run_sweep(0, 0, lat, gd, gf, f2, l1, fw, bk);
    check("arst.load_first", 64'(l1), 64'(1));
    verify("arst_rerun", lat, gd, gf, fw, bk);

    // START pulses while busy are ignored
    run_sweep(100, 2000, lat, gd, gf, f2, l1, fw, bk);
    verify("busy_start", lat, gd, gf, fw, bk);

    // Two windows, passing-tap total counted across both
    clear_mask(); set_pass(5, 9); set_pass(40, 79);
    run_sweep(0, 0, lat, gd, gf, f2, l1, fw, bk);
    verify("two_win", lat, gd, gf, fw, bk);

    // Random masks
    for (int r = 0; r < 3; r++) begin
      int nw;
      clear_mask();
      nw = $urandom_range(1, 3);
      for (int i = 0; i < nw; i++) begin
        int a;
        a = $urandom_range(0, NUM_TAPS - 1);
        set_pass(a, a + $urandom_range(0, 30));
      end
      for (int i = 0; i < 4; i++) pass_mask[$urandom_range(0, NUM_TAPS - 1)] = 1'b1;
      run_sweep(0, 0, lat, gd, gf, f2, l1, fw, bk);
      verify($sformatf("rand%0d", r), lat, gd, gf, fw, bk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/ddr3_read_training_tap_sweep.md
Name: ddr3_read_training_tap_sweep

Overview:
- Per-lane DQ read-training sequencer that sits directly upstream of the lane's read-training IOD.
- Drives the IOD delay-line controls (LOAD/MOVE/DIRECTION) and the eye-monitor flag clear.
- Consumes the IOD's EYE_MONITOR_EARLY/LATE and DELAY_LINE_OUT_OF_RANGE outputs.
- Sweeps every delay tap, finds the widest contiguous passing window, parks the delay line at its centre and reports the result to the PHY training controller.

Parameters:
- NUM_TAPS, 128, number of delay taps swept (taps 0..NUM_TAPS-1).
- TAP_W, 7, tap index width; must satisfy 2**TAP_W >= NUM_TAPS.
- SETTLE_CYCLES, 8, idle cycles after a tap change or flag clear before sampling.
- SAMPLE_CYCLES, 16, cycles the eye-monitor flags are observed per tap.
- MIN_EYE, 8, minimum passing-window width; a narrower best window flags FAIL.

Ports:
- FAB_CLK  in  1  fabric clock, shared with the IOD RX_CLK/TX_CLK.
- ARST  in  1  asynchronous active-high reset.
- START  in  1  one-cycle pulse that begins training; ignored while BUSY.
- BUSY  out  1  high from the cycle after an accepted START until DONE/FAIL.
- DONE  out  1  one-cycle pulse on successful completion.
- FAIL  out  1  sticky; set on failure, cleared by the next accepted START.
- TAP_OUT  out  TAP_W  current delay-line tap as tracked by this block.
- EYE_START  out  TAP_W  first tap of the best window.
- EYE_WIDTH  out  TAP_W+1  width of the best window, in taps.
- DELAY_LINE_LOAD  out  1  to IOD; pulse resets the delay line to tap 0.
- DELAY_LINE_MOVE  out  1  to IOD; one-cycle step pulse.
- DELAY_LINE_DIRECTION  out  1  to IOD; 1 = increment, 0 = decrement.
- EYE_MONITOR_CLEAR_FLAGS  out  1  to IOD; one-cycle flag-clear pulse.
- EYE_MONITOR_EARLY  in  1  from IOD.
- EYE_MONITOR_LATE  in  1  from IOD.
- DELAY_LINE_OUT_OF_RANGE  in  1  from IOD.

Behaviour:
- Reset values: all outputs 0. The FSM enters IDLE. All counters and window registers are cleared.
- FSM states and transitions:
  - IDLE: START=1 -> LOAD.
  - LOAD: LOAD=1 for 1 cycle; TAP_OUT<=0; clear cur_start/cur_len/best_start/best_len; clear FAIL -> CLEAR.
  - CLEAR: CLEAR_FLAGS=1 for 1 cycle -> SETTLE.
  - SETTLE: count SETTLE_CYCLES -> SAMPLE.
  - SAMPLE: for SAMPLE_CYCLES, OR-accumulate EARLY|LATE into `bad` -> EVAL.
  - EVAL (1 cycle):
    - If !bad: if cur_len==0 then cur_start<=TAP_OUT; cur_len<=cur_len+1.
    - If bad: cur_len<=0.
    - Best-window compare uses the updated cur_len. If it is strictly greater than best_len, copy cur_start/len into best. Ties keep the earlier window.
    - Next state: TAP_OUT==NUM_TAPS-1 -> CALC; otherwise -> STEP.
  - STEP: MOVE=1, DIRECTION=1 for 1 cycle; TAP_OUT+1 -> CLEAR.
  - CALC:
    - best_len<MIN_EYE -> FAIL_S.
    - Otherwise centre = best_start + (best_len>>1), truncating division -> CENTER.
  - CENTER: while TAP_OUT != centre, issue one MOVE pulse with DIRECTION=0 every 2 cycles (pulse, gap), decrementing TAP_OUT per pulse -> DONE_S.
  - DONE_S: DONE=1 for 1 cycle; EYE_START/EYE_WIDTH registered -> IDLE.
  - FAIL_S: FAIL<=1; TAP_OUT is left at the last swept tap -> IDLE.
- DIRECTION is held stable from the cycle before MOVE through the MOVE cycle.
- MOVE, LOAD and CLEAR_FLAGS are never asserted in the same cycle.
- DELAY_LINE_OUT_OF_RANGE sampled high in STEP or CENTER: abort -> FAIL_S. The in-progress tap is not counted.
- A window still open at the last tap is closed and compared in that final EVAL.
- START while BUSY is ignored, with no side effects.
- ARST asserted mid-sweep returns the block to reset values immediately. The IOD delay line is not restored; the next START re-LOADs it.
- BUSY is asserted in every non-IDLE state.
- Latency: START to DONE = 2 + NUM_TAPS*(1+SETTLE+SAMPLE+1) + NUM_TAPS-1 (STEPs) + 1 + 2*(NUM_TAPS-1-centre) + 1 cycles.

Optional Feature:
- Macro: RT_PASS_COUNT_EN.
- Defined: adds output PASS_COUNT (TAP_W+1 bits), the total number of passing taps in the sweep, non-contiguous taps included. It is cleared in LOAD, incremented in EVAL when !bad, and valid from DONE/FAIL until the next START.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- IOD model passes taps 40..79 only; pulse START -> 40 forward MOVEs past tap 40; DONE; EYE_START=40, EYE_WIDTH=40, TAP_OUT=60; exactly 67 decrement MOVE pulses.
- Passing windows at taps 10..19 and 50..59 (tie) -> EYE_START=10, EYE_WIDTH=10, TAP_OUT=15.
- Only taps 100..104 pass (width 5 < MIN_EYE) -> FAIL=1, no DONE, TAP_OUT=127, BUSY low; a new START clears FAIL.
- DELAY_LINE_OUT_OF_RANGE forced high at forward step 30 -> FAIL=1, no further MOVE pulses, BUSY=0 next cycle.
- ARST pulsed during SAMPLE at tap 20 -> all outputs 0 in the same cycle; a subsequent START issues DELAY_LINE_LOAD first.
- START pulsed twice while BUSY -> ignored, results unchanged. Under RT_PASS_COUNT_EN with taps 5..9 and 40..79 passing -> PASS_COUNT=45.
